// File: rtl/mc_core_pkg.sv
// mc_core_pkg: shared definitions for the multi-cycle 16-bit-encoding core.
//   - opcode values (instruction bits [15:12])
//   - FSM state encoding
//   - sext4: sign-extend the 4-bit C field to 32 bits (callers cast to width)
package mc_core_pkg;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_SLT  = 4'h4;
   localparam logic [3:0] OP_LW   = 4'h8;
   localparam logic [3:0] OP_SW   = 4'h9;
   localparam logic [3:0] OP_BNE  = 4'hA;
   localparam logic [3:0] OP_BEQ  = 4'hB;
   localparam logic [3:0] OP_ADDI = 4'hC;
   localparam logic [3:0] OP_JMP  = 4'hD;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   function automatic logic signed [31:0] sext4(input logic [3:0] v);
      return {{28{v[3]}}, v};
   endfunction

endpackage

// File: rtl/mc_reg_file.sv
// mc_reg_file: NUM_REGS x DATA_W register file.
//   clk, rst_n        clock, async active-low reset (clears all registers)
//   ra_addr/ra_data   async read port A
//   rb_addr/rb_data   async read port B
//   dbg_addr/dbg_data async debug read port
//   we/wr_addr/wr_data synchronous write port
// r0 and indices >= NUM_REGS read as 0; writes to them are dropped.
module mc_reg_file #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned NUM_REGS = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        ra_addr,
   input  logic [3:0]        rb_addr,
   input  logic [3:0]        dbg_addr,
   input  logic              we,
   input  logic [3:0]        wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] ra_data,
   output logic [DATA_W-1:0] rb_data,
   output logic [DATA_W-1:0] dbg_data
);

   logic [DATA_W-1:0] regs [NUM_REGS];

   function automatic logic valid_idx(input logic [3:0] a);
      return (a != 4'd0) && (32'(a) < NUM_REGS);
   endfunction

   assign ra_data  = valid_idx(ra_addr)  ? regs[ra_addr]  : '0;
   assign rb_data  = valid_idx(rb_addr)  ? regs[rb_addr]  : '0;
   assign dbg_data = valid_idx(dbg_addr) ? regs[dbg_addr] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs <= '{default: '0};
      end else if (we && valid_idx(wr_addr)) begin
         regs[wr_addr] <= wr_data;
      end
   end

endmodule

// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multi-cycle CPU, encoding op[15:12] A[11:8] B[7:4] C[3:0].
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   imem_req/imem_addr/imem_ack/imem_rdata   instruction fetch handshake
//   dmem_req/dmem_we/dmem_addr/dmem_wdata/dmem_ack/dmem_rdata  data handshake
//   pc, halted, retire                  status (retire = 1-cycle pulse per instr)
//   dbg_addr/dbg_data                   combinational register peek
//   perf_cycles/perf_instr              performance counters
// Build option: define CORE_PERF_CNT_EN to include the performance counters;
// otherwise perf_cycles/perf_instr are tied to 0.
module mips_multicycle_core
   import mc_core_pkg::*;
#(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned NUM_REGS = 16,
   parameter int unsigned RESET_PC = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [15:0]       imem_rdata,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic [ADDR_W-1:0] pc,
   output logic              halted,
   output logic              retire,
   input  logic [3:0]        dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic [31:0]       perf_cycles,
   output logic [31:0]       perf_instr
);

   state_t            state;
   logic [15:0]       ir;
   logic [3:0]        op, fa, fb, fc;
   logic [DATA_W-1:0] ra_data, rb_data, ra_q, rb_q, imm_q, alu_y, wb_data;
   logic [3:0]        wb_dest;
   logic [ADDR_W-1:0] pc_inc, br_tgt, next_pc;

   assign op = ir[15:12];
   assign fa = ir[11:8];
   assign fb = ir[7:4];
   assign fc = ir[3:0];

   assign imem_addr = pc;
   assign pc_inc    = pc + ADDR_W'(1);
   assign br_tgt    = pc_inc + ADDR_W'(sext4(fc));

   mc_reg_file #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS)
   ) u_rf (
      .clk      (clk),
      .rst_n    (rst_n),
      .ra_addr  (fa),
      .rb_addr  (fb),
      .dbg_addr (dbg_addr),
      .we       (state == S_WB),
      .wr_addr  (wb_dest),
      .wr_data  (wb_data),
      .ra_data  (ra_data),
      .rb_data  (rb_data),
      .dbg_data (dbg_data)
   );

   // ALU; ADDI/LW/SW share the default rA+imm path.
   always_comb begin
      alu_y = ra_q + imm_q;
      case (op)
         OP_ADD:  alu_y = ra_q + rb_q;
         OP_SUB:  alu_y = ra_q - rb_q;
         OP_AND:  alu_y = ra_q & rb_q;
         OP_OR:   alu_y = ra_q | rb_q;
         OP_SLT:  alu_y = DATA_W'($signed(ra_q) < $signed(rb_q));
         default: ;
      endcase
   end

   // Next PC for instructions that complete in EXEC (branches, JMP, NOPs).
   always_comb begin
      next_pc = pc_inc;
      case (op)
         OP_BNE:  if (ra_q != rb_q) next_pc = br_tgt;
         OP_BEQ:  if (ra_q == rb_q) next_pc = br_tgt;
         OP_JMP:  next_pc = ADDR_W'(ir[11:0]);
         default: ;
      endcase
   end

   // imem_req is registered so reset drops it asynchronously; it is raised
   // together with the move into FETCH, except in the first cycle after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_FETCH;
         pc         <= ADDR_W'(RESET_PC);
         ir         <= '0;
         ra_q       <= '0;
         rb_q       <= '0;
         imm_q      <= '0;
         wb_data    <= '0;
         wb_dest    <= '0;
         imem_req   <= 1'b0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         retire     <= 1'b0;
         halted     <= 1'b0;
      end else begin
         retire <= 1'b0;
         unique case (state)
            S_FETCH: begin
               if (!imem_req) begin
                  imem_req <= 1'b1;
               end else if (imem_ack) begin
                  ir       <= imem_rdata;
                  imem_req <= 1'b0;
                  state    <= S_DECODE;
               end
            end
            S_DECODE: begin
               ra_q  <= ra_data;
               rb_q  <= rb_data;
               imm_q <= DATA_W'(sext4(fc));
               state <= S_EXEC;
            end
            S_EXEC: begin
               case (op)
                  OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
                     wb_data <= alu_y;
                     wb_dest <= fc;
                     state   <= S_WB;
                  end
                  OP_ADDI: begin
                     wb_data <= alu_y;
                     wb_dest <= fb;
                     state   <= S_WB;
                  end
                  OP_LW, OP_SW: begin
                     dmem_req   <= 1'b1;
                     dmem_we    <= (op == OP_SW);
                     dmem_addr  <= ADDR_W'(alu_y);
                     dmem_wdata <= rb_q;
                     wb_dest    <= fb;
                     state      <= S_MEM;
                  end
                  OP_HALT: begin
                     halted <= 1'b1;
                     state  <= S_HALT;
                  end
                  default: begin
                     pc       <= next_pc;
                     retire   <= 1'b1;
                     imem_req <= 1'b1;
                     state    <= S_FETCH;
                  end
               endcase
            end
            S_MEM: begin
               if (dmem_ack) begin
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  if (dmem_we) begin
                     pc       <= pc_inc;
                     retire   <= 1'b1;
                     imem_req <= 1'b1;
                     state    <= S_FETCH;
                  end else begin
                     wb_data <= dmem_rdata;
                     state   <= S_WB;
                  end
               end
            end
            S_WB: begin
               pc       <= pc_inc;
               retire   <= 1'b1;
               imem_req <= 1'b1;
               state    <= S_FETCH;
            end
            S_HALT: ;
            default: state <= S_FETCH;
         endcase
      end
   end

`ifdef CORE_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_cycles <= '0;
         perf_instr  <= '0;
      end else begin
         if (state != S_HALT) perf_cycles <= perf_cycles + 32'd1;
         if (retire)          perf_instr  <= perf_instr + 32'd1;
      end
   end
`else
   assign perf_cycles = '0;
   assign perf_instr  = '0;
`endif

endmodule
